// File: rtl/m_layer_output_2.sv
// ============================================================================
// m_layer_output_2 : output reorder buffer, pixel-major in / channel-major out
// Rev 1.0
// ============================================================================
`default_nettype none

module m_layer_output_2 #(
  parameter int MAP_PIX     = 324,
  parameter int CH_PER_LOOP = 4,
  parameter int NUM_LOOP    = 4,
  parameter int RELU        = 1,
  parameter int ADDR_W      = 13
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic signed [15:0] res_in,
  input  logic               res_valid,
  output logic signed [15:0] map_out,
  output logic               wr,
  output logic               ready,
  output logic               done,
  output logic               err
);

  localparam int TOTAL = MAP_PIX * CH_PER_LOOP * NUM_LOOP;
  localparam int K_W   = (CH_PER_LOOP > 1) ? $clog2(CH_PER_LOOP) : 1;
  localparam int P_W   = (MAP_PIX > 1)     ? $clog2(MAP_PIX)     : 1;
  localparam int L_W   = (NUM_LOOP > 1)    ? $clog2(NUM_LOOP)    : 1;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DRAIN   = 2'd1,
    S_FLUSH   = 2'd2,
    S_FIN     = 2'd3
  } state_t;

  state_t              state_q;
  logic [K_W-1:0]      k_q, k_d;
  logic [P_W-1:0]      pix_q, pix_d;
  logic [L_W-1:0]      loop_q, loop_d;
  logic [ADDR_W-1:0]   addr_rd_q;
  logic                w1_valid_q;
  logic [ADDR_W-1:0]   w1_addr_q, w1_addr_d;
  logic signed [15:0]  w1_data_q, w1_data_d;
  logic                k_last, pix_last, loop_last, accept;

  logic signed [15:0]  mem [0:TOTAL-1];

  always_comb begin
    k_last    = (k_q    == K_W'(CH_PER_LOOP - 1));
    pix_last  = (pix_q  == P_W'(MAP_PIX - 1));
    loop_last = (loop_q == L_W'(NUM_LOOP - 1));
    accept    = res_valid && (state_q == S_COLLECT);

    k_d    = k_q;
    pix_d  = pix_q;
    loop_d = loop_q;
    // k innermost, then pix, then loop; each wraps when the one inside it wraps
    if (k_last) begin
      k_d = '0;
      if (pix_last) begin
        pix_d  = '0;
        loop_d = loop_last ? '0 : loop_q + L_W'(1);
      end else begin
        pix_d = pix_q + P_W'(1);
      end
    end else begin
      k_d = k_q + K_W'(1);
    end

    w1_addr_d = (ADDR_W'(loop_q) * ADDR_W'(CH_PER_LOOP) + ADDR_W'(k_q)) * ADDR_W'(MAP_PIX)
                + ADDR_W'(pix_q);
    w1_data_d = ((RELU != 0) && res_in[15]) ? 16'sd0 : res_in;
  end

  always_ff @(posedge clk_in) begin
    if (w1_valid_q) mem[w1_addr_q] <= w1_data_q;
  end

  always_ff @(posedge clk_in or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_COLLECT;
      k_q        <= '0;
      pix_q      <= '0;
      loop_q     <= '0;
      addr_rd_q  <= '0;
      w1_valid_q <= 1'b0;
      w1_addr_q  <= '0;
      w1_data_q  <= '0;
      map_out    <= '0;
      wr         <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      w1_valid_q <= accept;
      wr         <= 1'b0;
      if (accept) begin
        w1_addr_q <= w1_addr_d;
        w1_data_q <= w1_data_d;
        k_q       <= k_d;
        pix_q     <= pix_d;
        loop_q    <= loop_d;
      end
      if (res_valid && (state_q != S_COLLECT)) err <= 1'b1;

      case (state_q)
        S_COLLECT: begin
          if (accept && k_last && pix_last && loop_last) begin
            state_q <= S_DRAIN;
            ready   <= 1'b0;
          end
        end
        S_DRAIN: begin
          // The final collected word lands at TOTAL-1 on the edge reading 0, so no collision
          map_out   <= mem[addr_rd_q];
          wr        <= 1'b1;
          addr_rd_q <= addr_rd_q + ADDR_W'(1);
          if (addr_rd_q == ADDR_W'(TOTAL - 1)) state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          state_q <= S_FIN;
          done    <= 1'b1;
        end
        default: state_q <= S_FIN;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_m_layer_output_2.sv
// ============================================================================
// tb_m_layer_output_2 : self-checking bench for the output reorder buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_m_layer_output_2;

  typedef struct {
    int din;
    int exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic vld_s, vld_d;
  logic signed [15:0] din_s, din_d;
  logic signed [15:0] mo_s, mo_r, mo_d;
  logic wr_s, wr_r, wr_d, rdy_s, rdy_r, rdy_d, dn_s, dn_r, dn_d, er_s, er_r, er_d;

  always #5 clk = ~clk;

  m_layer_output_2 #(.MAP_PIX(4), .CH_PER_LOOP(2), .NUM_LOOP(2), .RELU(0), .ADDR_W(4)) u_s (
    .clk_in(clk), .rst_n(rst), .res_in(din_s), .res_valid(vld_s),
    .map_out(mo_s), .wr(wr_s), .ready(rdy_s), .done(dn_s), .err(er_s));

  m_layer_output_2 #(.MAP_PIX(4), .CH_PER_LOOP(2), .NUM_LOOP(2), .RELU(1), .ADDR_W(4)) u_r (
    .clk_in(clk), .rst_n(rst), .res_in(din_s), .res_valid(vld_s),
    .map_out(mo_r), .wr(wr_r), .ready(rdy_r), .done(dn_r), .err(er_r));

  m_layer_output_2 u_d (
    .clk_in(clk), .rst_n(rst), .res_in(din_d), .res_valid(vld_d),
    .map_out(mo_d), .wr(wr_d), .ready(rdy_d), .done(dn_d), .err(er_d));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic signed [15:0] outq [3][$];
  int   first_wr [3], last_wr [3], ready_fall [3], done_rise [3], gaps [3];
  logic prev_wr [3], prev_rdy [3], prev_dn [3];

  vec_t tbl [16];
  int   din_arr [16];
  int   exp_s [16], exp_r [16], exp_t [16];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int addr_of(input int n, input int mp, input int ch);
    return ((n / (mp * ch)) * ch + n % ch) * mp + (n / ch) % mp;
  endfunction

  task automatic mon();
    logic cw [3], cr [3], cd [3];
    logic signed [15:0] cm [3];
    cyc++;
    cw = '{wr_s, wr_r, wr_d};
    cr = '{rdy_s, rdy_r, rdy_d};
    cd = '{dn_s, dn_r, dn_d};
    cm = '{mo_s, mo_r, mo_d};
    for (int i = 0; i < 3; i++) begin
      if (cw[i]) begin
        if (outq[i].size() > 0 && !prev_wr[i]) gaps[i]++;
        if (outq[i].size() == 0) first_wr[i] = cyc;
        last_wr[i] = cyc;
        outq[i].push_back(cm[i]);
      end
      if (prev_rdy[i] && !cr[i]) ready_fall[i] = cyc;
      if (!prev_dn[i] && cd[i]) done_rise[i] = cyc;
      prev_wr[i] = cw[i]; prev_rdy[i] = cr[i]; prev_dn[i] = cd[i];
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 3; i++) begin
      outq[i].delete();
      first_wr[i] = -1; last_wr[i] = -1; ready_fall[i] = -1; done_rise[i] = -1; gaps[i] = 0;
    end
    prev_wr  = '{wr_s, wr_r, wr_d};
    prev_rdy = '{rdy_s, rdy_r, rdy_d};
    prev_dn  = '{dn_s, dn_r, dn_d};
  endtask

  task automatic cyc1(input logic vs, input int ds, input logic vd, input int dd);
    vld_s = vs; din_s = 16'(ds); vld_d = vd; din_d = 16'(dd);
    @(posedge clk);
    @(negedge clk);
    mon();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld_s = 1'b0; vld_d = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
  endtask

  // Feeds din_arr into the small instances; gapped mode idles 1 cycle on every
  // other word plus 0..5 random cycles before each word.
  task automatic feed_s(input bit gapped, output int last_cyc);
    for (int n = 0; n < 16; n++) begin
      if (gapped) begin
        int g;
        g = (n % 2) + int'($urandom_range(0, 5));
        for (int j = 0; j < g; j++) cyc1(1'b0, 0, 1'b0, 0);
      end
      cyc1(1'b1, din_arr[n], 1'b0, 0);
    end
    last_cyc = cyc;
    vld_s = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int budget, input string nm);
    int t;
    logic d;
    t = 0;
    d = (idx == 0) ? dn_s : dn_d;
    while (!d && t < budget) begin
      cyc1(1'b0, 0, 1'b0, 0);
      d = (idx == 0) ? dn_s : dn_d;
      t++;
    end
    if (!d) chk({nm, "_done_timeout"}, 0, 1);
    cyc1(1'b0, 0, 1'b0, 0);
  endtask

  task automatic chk_timing(input int idx, input string nm, input int n_exp, input int last_feed);
    chk({nm, "_count"}, outq[idx].size(), n_exp);
    chk({nm, "_gaps"}, gaps[idx], 0);
    chk({nm, "_ready_fall"}, ready_fall[idx], last_feed);
    chk({nm, "_first_wr"}, first_wr[idx], ready_fall[idx] + 1);
    chk({nm, "_done_rise"}, done_rise[idx], last_wr[idx] + 1);
  endtask

  task automatic chk_stream(input int idx, input string nm, input int ex [16]);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_word%0d", nm, i), (i < outq[idx].size()) ? int'(outq[idx][i]) : -99999, ex[i]);
  endtask

  initial begin
    int lf;
    tbl = '{'{0, 0}, '{10, 1}, '{1, 2}, '{11, 3}, '{2, 10}, '{12, 11}, '{3, 12}, '{13, 13},
            '{100, 100}, '{110, 101}, '{101, 102}, '{111, 103},
            '{102, 110}, '{112, 111}, '{103, 112}, '{113, 113}};
    for (int i = 0; i < 16; i++) begin
      din_arr[i] = tbl[i].din;
      exp_t[i]   = tbl[i].exp;
    end

    // Reset state
    do_reset();
    chk("rst_ready", rdy_s, 1);
    chk("rst_wr", wr_s, 0);
    chk("rst_done", dn_s, 0);
    chk("rst_err", er_s, 0);
    chk("rst_map_out", mo_s, 0);
    chk("rst_ready_d", rdy_d, 1);

    // Back-to-back feed of the directed table
    feed_s(1'b0, lf);
    wait_done(0, 40, "b2b");
    chk_timing(0, "b2b", 16, lf);
    chk_stream(0, "b2b", exp_t);
    chk_stream(1, "b2b_relu", exp_t);
    chk("b2b_err", er_s, 0);

    // res_valid after completion is ignored and flagged
    for (int j = 0; j < 3; j++) cyc1(1'b1, 7, 1'b0, 0);
    cyc1(1'b0, 0, 1'b0, 0);
    chk("late_err", er_s, 1);
    chk("late_no_wr", outq[0].size(), 16);
    chk("late_done", dn_s, 1);

    // Gapped feed must give the identical, contiguous stream
    do_reset();
    chk("rst2_err", er_s, 0);
    feed_s(1'b1, lf);
    wait_done(0, 40, "gap");
    chk_timing(0, "gap", 16, lf);
    chk_stream(0, "gap", exp_t);

    // Random words with the ReLU corner values on the first four slots
    do_reset();
    for (int n = 0; n < 16; n++) din_arr[n] = int'($signed(16'($urandom)));
    din_arr[0] = -1; din_arr[1] = -32768; din_arr[2] = 0; din_arr[3] = 32767;
    for (int n = 0; n < 16; n++) begin
      exp_s[addr_of(n, 4, 2)] = din_arr[n];
      exp_r[addr_of(n, 4, 2)] = (din_arr[n] < 0) ? 0 : din_arr[n];
    end
    feed_s(1'b1, lf);
    wait_done(0, 40, "rnd");
    chk_stream(0, "rnd_raw", exp_s);
    chk_stream(1, "rnd_relu", exp_r);
    chk("relu_slot0", (outq[1].size() > 0) ? int'(outq[1][0]) : -1, 0);
    chk("relu_slot3", (outq[1].size() > 5) ? int'(outq[1][5]) : -1, 32767);

    // Reset in the middle of the drain aborts the stream at once
    do_reset();
    for (int i = 0; i < 16; i++) din_arr[i] = tbl[i].din;
    feed_s(1'b0, lf);
    begin
      int t;
      t = 0;
      while (outq[0].size() < 5 && t < 40) begin
        cyc1(1'b0, 0, 1'b0, 0);
        t++;
      end
      chk("abort_reach5", outq[0].size(), 5);
    end
    rst = 1'b1;
    #1;
    chk("abort_wr", wr_s, 0);
    chk("abort_ready", rdy_s, 1);
    chk("abort_done", dn_s, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    feed_s(1'b0, lf);
    wait_done(0, 40, "refeed");
    chk_timing(0, "refeed", 16, lf);
    chk_stream(0, "refeed", exp_t);

    // Default configuration: value written equals its own address
    do_reset();
    for (int n = 0; n < 5184; n++) begin
      while ($urandom_range(0, 3) == 0) cyc1(1'b0, 0, 1'b0, 0);
      cyc1(1'b0, 0, 1'b1, addr_of(n, 324, 4));
    end
    lf = cyc;
    vld_d = 1'b0;
    chk("dflt_ready_low", rdy_d, 0);
    wait_done(2, 6000, "dflt");
    chk_timing(2, "dflt", 5184, lf);
    begin
      int bad_at;
      bad_at = -1;
      for (int i = 0; i < outq[2].size(); i++)
        if (bad_at < 0 && int'(outq[2][i]) != i) bad_at = i;
      chk("dflt_order_first_bad_index", bad_at, -1);
    end
    chk("dflt_done_held", dn_d, 1);
    chk("dflt_err", er_d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
